// File: rtl/bist_array.sv
// Flop-based NUM x DATA_BITS array with combinational read and an optional March-style self-test.
// The self-test engine is built only when BIST_ARRAY_SELFTEST_EN is defined; otherwise its status outputs are tied to 0.
module bist_array #(
  parameter int ADDR_BITS = 5,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [DATA_BITS-1:0] wdata,
  output logic [DATA_BITS-1:0] rdata,
  input  logic                 fault_inj,
  input  logic                 bist_start,
  output logic                 bist_busy,
  output logic                 bist_done,
  output logic                 bist_fail,
  output logic [ADDR_BITS-1:0] bist_fail_addr
);

  localparam int NUM = 2 ** ADDR_BITS;

  logic [DATA_BITS-1:0] mem_q [NUM];
  logic                 mem_we;
  logic [ADDR_BITS-1:0] mem_waddr;
  logic [DATA_BITS-1:0] mem_wdata;
  logic [DATA_BITS-1:0] func_rdata;

  // The fault hook forces bit 0 of word 0 on every read path, including the self-test compare.
  function automatic logic [DATA_BITS-1:0] read_word(input logic [DATA_BITS-1:0] w,
                                                     input logic [ADDR_BITS-1:0] a,
                                                     input logic             inj);
    read_word = w;
    if (inj && (a == '0)) read_word[0] = 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign func_rdata = read_word(mem_q[addr], addr, fault_inj);

`ifdef BIST_ARRAY_SELFTEST_EN
  localparam logic [ADDR_BITS-1:0] ADDR_MAX = '1;

  typedef enum logic [2:0] {S_IDLE, S_M0, S_M1, S_M2, S_M3, S_M4, S_M5} state_e;

  state_e               state_q, state_d;
  logic [ADDR_BITS-1:0] baddr_q, baddr_d;
  logic [ADDR_BITS-1:0] fail_addr_q, fail_addr_d;
  logic                 done_q, done_d;
  logic                 fail_q, fail_d;
  logic                 busy;
  logic                 chk_en, wr_en, down, last;
  logic [DATA_BITS-1:0] exp_dat, wr_dat, bist_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      baddr_q     <= '0;
      fail_addr_q <= '0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      baddr_q     <= baddr_d;
      fail_addr_q <= fail_addr_d;
      done_q      <= done_d;
      fail_q      <= fail_d;
    end
  end

  assign bist_rdata = read_word(mem_q[baddr_q], baddr_q, fault_inj);

  always_comb begin
    state_d     = state_q;
    baddr_d     = baddr_q;
    fail_addr_d = fail_addr_q;
    done_d      = done_q;
    fail_d      = fail_q;
    unique case (state_q)
      S_IDLE: begin
        if (bist_start) begin
          state_d     = S_M0;
          baddr_d     = '0;
          fail_addr_d = '0;
          done_d      = 1'b0;
          fail_d      = 1'b0;
        end
      end
      default: begin
        if (chk_en && (bist_rdata != exp_dat)) begin
          fail_d = 1'b1;
          if (!fail_q) fail_addr_d = baddr_q;
        end
        if (last) begin
          // Each element reloads the address for the direction of its successor.
          case (state_q)
            S_M0:    begin state_d = S_M1; baddr_d = '0;       end
            S_M1:    begin state_d = S_M2; baddr_d = '0;       end
            S_M2:    begin state_d = S_M3; baddr_d = ADDR_MAX; end
            S_M3:    begin state_d = S_M4; baddr_d = ADDR_MAX; end
            S_M4:    begin state_d = S_M5; baddr_d = ADDR_MAX; end
            default: begin state_d = S_IDLE; baddr_d = '0; done_d = 1'b1; end
          endcase
        end else begin
          baddr_d = down ? (baddr_q - 1'b1) : (baddr_q + 1'b1);
        end
      end
    endcase
  end

  always_comb begin
    chk_en  = 1'b0;
    wr_en   = 1'b0;
    down    = 1'b0;
    exp_dat = '0;
    wr_dat  = '0;
    case (state_q)
      S_M0: wr_en = 1'b1;
      S_M1: begin chk_en = 1'b1; wr_en = 1'b1; wr_dat = '1; end
      S_M2: begin chk_en = 1'b1; wr_en = 1'b1; exp_dat = '1; end
      S_M3: begin down = 1'b1; chk_en = 1'b1; wr_en = 1'b1; wr_dat = '1; end
      S_M4: begin down = 1'b1; chk_en = 1'b1; wr_en = 1'b1; exp_dat = '1; end
      S_M5: begin down = 1'b1; chk_en = 1'b1; end
      default: ;
    endcase
    last = down ? (baddr_q == '0) : (baddr_q == ADDR_MAX);
  end

  assign busy           = (state_q != S_IDLE);
  assign mem_we         = busy ? wr_en   : we;
  assign mem_waddr      = busy ? baddr_q : addr;
  assign mem_wdata      = busy ? wr_dat  : wdata;
  assign rdata          = busy ? '0      : func_rdata;
  assign bist_busy      = busy;
  assign bist_done      = done_q;
  assign bist_fail      = fail_q;
  assign bist_fail_addr = fail_addr_q;
`else
  logic unused_bist_start;
  logic unused_rst_n;
  assign unused_bist_start = bist_start;
  assign unused_rst_n      = rst_n;

  assign mem_we         = we;
  assign mem_waddr      = addr;
  assign mem_wdata      = wdata;
  assign rdata          = func_rdata;
  assign bist_busy      = 1'b0;
  assign bist_done      = 1'b0;
  assign bist_fail      = 1'b0;
  assign bist_fail_addr = '0;
`endif

endmodule

// File: tb/tb_bist_array.sv
// Directed bench for bist_array: functional access, fault hook, reset, and the self-test engine when built in.
module tb_bist_array;

  localparam int AB  = 5;
  localparam int DB  = 8;
  localparam int NUM = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          we = 1'b0;
  logic [AB-1:0] addr = '0;
  logic [DB-1:0] wdata = '0;
  logic [DB-1:0] rdata;
  logic          fault_inj = 1'b0;
  logic          bist_start = 1'b0;
  logic          bist_busy;
  logic          bist_done;
  logic          bist_fail;
  logic [AB-1:0] bist_fail_addr;

  int vectors = 0;
  int miscompares = 0;

  logic [DB-1:0] model [NUM];
  logic [31:0]   sb_q [$];
  string         tag_q [$];

  bist_array #(.ADDR_BITS(AB), .DATA_BITS(DB)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .we             (we),
    .addr           (addr),
    .wdata          (wdata),
    .rdata          (rdata),
    .fault_inj      (fault_inj),
    .bist_start     (bist_start),
    .bist_busy      (bist_busy),
    .bist_done      (bist_done),
    .bist_fail      (bist_fail),
    .bist_fail_addr (bist_fail_addr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] v);
    tag_q.push_back(tag);
    sb_q.push_back(v);
  endtask

  task automatic sb_pop(input logic [31:0] obs);
    if (sb_q.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL sb_underflow observed=0x%0h expected=<queued entry>", obs);
    end else begin
      check(tag_q.pop_front(), obs, sb_q.pop_front());
    end
  endtask

  task automatic wr(input logic [AB-1:0] a, input logic [DB-1:0] d);
    @(negedge clk);
    we = 1'b1; addr = a; wdata = d;
    model[a] = d;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic rd(input logic [AB-1:0] a, input string tag);
    @(negedge clk);
    addr = a;
    sb_push(tag, {24'h0, model[a]});
    #1 sb_pop({24'h0, rdata});
  endtask

  task automatic check_bist_zero(input string tag);
    check({tag, "_busy"}, bist_busy, 0);
    check({tag, "_done"}, bist_done, 0);
    check({tag, "_fail"}, bist_fail, 0);
    check({tag, "_fail_addr"}, bist_fail_addr, 0);
  endtask

`ifdef BIST_ARRAY_SELFTEST_EN
  // Pulses start, counts busy cycles, records the cycle bist_fail first shows, and optionally
  // pokes functional inputs mid-run or applies reset at cycle rst_at.
  task automatic run_bist(input int rst_at, input bit poke, output int cycles, output int first_fail);
    cycles = 0;
    first_fail = 0;
    @(negedge clk);
    bist_start = 1'b1;
    @(negedge clk);
    bist_start = 1'b0;
    while (bist_busy === 1'b1 && cycles < 1000) begin
      cycles++;
      if (cycles == 1) check("done_clr_at_start", bist_done, 0);
      if (first_fail == 0 && bist_fail === 1'b1) first_fail = cycles;
      if (poke && cycles == 10) begin
        we = 1'b1; addr = 5'd5; wdata = 8'hFF; bist_start = 1'b1;
        #1 check("rdata_zero_busy", rdata, 0);
      end
      if (poke && cycles == 12) begin
        we = 1'b0; bist_start = 1'b0;
      end
      if (cycles == rst_at) begin
        check("fail_before_rst", bist_fail, 1);
        rst_n = 1'b0;
        #1 check_bist_zero("midrun_rst");
        @(negedge clk);
        rst_n = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask
`endif

  initial begin
    int cyc;
    int ff;
    cyc = 0;
    ff = 0;

    #2 rst_n = 1'b0;
    #1 check_bist_zero("reset");

    // Release reset and write on the very first edge after it.
    @(negedge clk);
    rst_n = 1'b1; we = 1'b1; addr = 5'd3; wdata = 8'hA5;
    model[3] = 8'hA5;
    @(negedge clk);
    we = 1'b0;
    wr(5'd31, 8'h3C);
    rd(5'd3, "rd_a3");
    rd(5'd31, "rd_a31");

    // Read-during-write returns the old word.
    @(negedge clk);
    we = 1'b1; addr = 5'd3; wdata = 8'h11;
    sb_push("rdw_old", {24'h0, model[3]});
    #1 sb_pop({24'h0, rdata});
    model[3] = 8'h11;
    @(negedge clk);
    we = 1'b0;
    rd(5'd3, "rdw_new");

    wr(5'd0, 8'h00);
    wr(5'd1, 8'h00);
    fault_inj = 1'b1;
    @(negedge clk);
    addr = 5'd0;
    sb_push("fault_a0", 32'h01);
    #1 sb_pop({24'h0, rdata});
    rd(5'd1, "fault_a1_clean");
    rd(5'd3, "fault_a3_clean");
    fault_inj = 1'b0;
    rd(5'd0, "nofault_a0");

    // Reset leaves memory untouched.
    wr(5'd7, 8'h5A);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    rd(5'd7, "mem_after_rst");
    rd(5'd31, "mem_after_rst31");

`ifdef BIST_ARRAY_SELFTEST_EN
    run_bist(-1, 1'b0, cyc, ff);
    check("good_run_len", cyc, 192);
    check("good_done", bist_done, 1);
    check("good_fail", bist_fail, 0);
    for (int i = 0; i < NUM; i++) model[i] = 8'h00;
    for (int i = 0; i < NUM; i++) rd(AB'(i), "post_run_zero");

    fault_inj = 1'b1;
    run_bist(-1, 1'b0, cyc, ff);
    check("fault_run_len", cyc, 192);
    check("fault_first_cycle", ff, NUM + 2);
    check("fault_fail", bist_fail, 1);
    check("fault_fail_addr", bist_fail_addr, 0);
    check("fault_done", bist_done, 1);
    fault_inj = 1'b0;

    wr(5'd9, 8'h77);
    run_bist(-1, 1'b1, cyc, ff);
    check("poke_run_len", cyc, 192);
    check("poke_fail", bist_fail, 0);
    model[9] = 8'h00;
    rd(5'd5, "poke_a5_zero");
    rd(5'd9, "poke_a9_zero");
    @(negedge clk);
    check("poke_no_restart", bist_busy, 0);

    fault_inj = 1'b1;
    run_bist(50, 1'b0, cyc, ff);
    check("rst_run_stop", cyc, 50);
    fault_inj = 1'b0;
    run_bist(-1, 1'b0, cyc, ff);
    check("after_rst_len", cyc, 192);
    check("after_rst_done", bist_done, 1);
    check("after_rst_fail", bist_fail, 0);
`else
    @(negedge clk);
    bist_start = 1'b1;
    @(negedge clk);
    bist_start = 1'b0;
    check_bist_zero("nobist_c1");
    repeat (5) @(negedge clk);
    check_bist_zero("nobist_c6");
    wr(5'd12, 8'hC3);
    rd(5'd12, "nobist_rd12");
    rd(5'd31, "nobist_rd31");
`endif

    if (sb_q.size() != 0) begin
      vectors++;
      miscompares++;
      $error("FAIL sb_leftover observed=%0d expected=0", sb_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bist_array.md
BIST_ARRAY -- requirements
Module: bist_array

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 5: address width; depth NUM = 2**ADDR_BITS words.
REQ-002 SHALL have parameter DATA_BITS, default 8: word width.
REQ-003 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1: reset, asynchronous, active-low.
REQ-005 SHALL have port we  input  1: functional write enable.
REQ-006 SHALL have port addr  input  ADDR_BITS: functional address.
REQ-007 SHALL have port wdata  input  DATA_BITS: functional write data.
REQ-008 SHALL have port rdata  output  DATA_BITS: functional read data, combinational.
REQ-009 SHALL have port fault_inj  input  1: test hook; when high, bit 0 of the word at address 0 reads as 1 on all read paths.
REQ-010 SHALL have port bist_start  input  1: request one self-test run.
REQ-011 SHALL have port bist_busy  output  1: self-test in progress.
REQ-012 SHALL have port bist_done  output  1: sticky; last run completed.
REQ-013 SHALL have port bist_fail  output  1: sticky; last or current run saw a mismatch.
REQ-014 SHALL have port bist_fail_addr  output  ADDR_BITS: address of first mismatch in the run.

Function
REQ-015 Storage SHALL be NUM x DATA_BITS flops without reset; contents undefined after power-up.
REQ-016 When idle, rdata SHALL equal mem[addr] in the same cycle, with REQ-009 applied.
REQ-017 When idle and we=1, mem[addr] SHALL take wdata at the clock edge; read-during-write returns old data.
REQ-018 While bist_busy=1, we SHALL be ignored, rdata SHALL be 0, and bist_start SHALL be ignored.
REQ-019 bist_start=1 sampled while idle SHALL set bist_busy=1 next cycle, clear bist_done, bist_fail and bist_fail_addr, and enter element M0 at address 0.
REQ-020 FSM states SHALL be IDLE, M0..M5, one address per cycle per element; each element takes NUM cycles.
REQ-021 M0 (addr up): write all-0.
REQ-022 M1 (addr up): read, expect all-0; write all-1.
REQ-023 M2 (addr up): read, expect all-1; write all-0.
REQ-024 M3 (addr down from NUM-1): read, expect all-0; write all-1.
REQ-025 M4 (addr down): read, expect all-1; write all-0.
REQ-026 M5 (addr down): read, expect all-0; no write.
REQ-027 Read and compare SHALL use the combinational read of the current address; the write SHALL occur at the same edge.
REQ-028 At an element's last address (NUM-1 up, 0 down), the next element SHALL start next cycle with the address reloaded.
REQ-029 A mismatch SHALL set bist_fail=1 next cycle; bist_fail_addr SHALL latch only on the first mismatch of the run.
REQ-030 The run SHALL continue to completion after a failure.
REQ-031 After the last M5 cycle, next cycle: bist_busy=0, bist_done=1; total busy duration exactly 6*NUM cycles.
REQ-032 After a run, every word SHALL hold all-0.

Reset
REQ-033 rst_n=0 SHALL immediately force FSM=IDLE, bist_busy=0, bist_done=0, bist_fail=0, bist_fail_addr=0, also mid-run.
REQ-034 Reset SHALL NOT alter memory contents.
REQ-035 After rst_n rises, the block SHALL be idle and accept functional access on the first edge.

Configuration
REQ-036 With macro BIST_ARRAY_SELFTEST_EN defined, the BIST engine per REQ-018..REQ-032 SHALL be present.
REQ-037 Without BIST_ARRAY_SELFTEST_EN, no FSM SHALL be built; bist_busy, bist_done, bist_fail and bist_fail_addr SHALL be constant 0; bist_start SHALL be ignored; functional behaviour SHALL be unchanged.

Verification
REQ-038 Defaults; write 0xA5 to addr 3, then 0x3C to addr 31, then read 3 and 31 -> rdata 0xA5, then 0x3C.
REQ-039 Pulse bist_start, fault_inj=0 -> bist_busy high for exactly 192 cycles; then bist_done=1, bist_fail=0; every address then reads 0x00.
REQ-040 fault_inj=1, run BIST -> bist_fail=1 in M0's successor (M1, addr 0); bist_fail_addr=0; bist_done=1 after 192 cycles.
REQ-041 During a run, assert we=1 with addr=5, wdata=0xFF and pulse bist_start again -> run length unchanged; addr 5 reads 0x00 after the run; rdata=0 while busy.
REQ-042 Assert rst_n=0 at cycle 50 of a run -> all BIST outputs 0 immediately; a new start then completes normally in 192 cycles.
REQ-043 Build without BIST_ARRAY_SELFTEST_EN; pulse bist_start -> all BIST outputs stay 0; REQ-038 still passes.
